// File: rtl/ysyx_040729_exe_alu_div_ctrl_if.sv
// -----------------------------------------------------------------------------
// ysyx_040729_exe_alu_div_ctrl_if
//
// Purpose:
//   Bundles every non-clock/reset signal of the EXE-stage divide controller.
//   This covers the ALU request side, the divider handshake side and the
//   result side.
//
// Modports:
//   master : the controller's view. It accepts requests, drives the divider
//            request and the result.
//   slave  : the environment's view. This is the ALU plus the iterative
//            divider.
//
// Signals (directions as seen by the controller):
//   req_valid     in   ALU presents a divide op
//   req_ready     out  controller idle, can accept
//   op_unsigned   in   1 = DIVU/REMU(W)
//   op_rem        in   1 = remainder, 0 = quotient
//   op_word       in   1 = W form, 32-bit operands in src[31:0]
//   src1 / src2   in   dividend / divisor
//   flush         in   pipeline flush, kills the in-flight op
//   div_valid     out  request to divider
//   div_ready     in   divider idle
//   divw          out  word-mode iteration count to divider
//   div_dividend  out  magnitude dividend to divider
//   div_divisor   out  magnitude divisor to divider
//   div_flush     out  abort to divider
//   div_out_valid in   divider result strobe
//   div_quotient  in   unsigned quotient from divider
//   div_remainder in   unsigned remainder from divider
//   res_valid     out  one-cycle result pulse
//   res           out  final result
//   busy          out  op in flight (stall EXE)
// -----------------------------------------------------------------------------
interface ysyx_040729_exe_alu_div_ctrl_if #(
    parameter int XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic            op_unsigned;
    logic            op_rem;
    logic            op_word;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            flush;

    logic            div_valid;
    logic            div_ready;
    logic            divw;
    logic [XLEN-1:0] div_dividend;
    logic [XLEN-1:0] div_divisor;
    logic            div_flush;
    logic            div_out_valid;
    logic [XLEN-1:0] div_quotient;
    logic [XLEN-1:0] div_remainder;

    logic            res_valid;
    logic [XLEN-1:0] res;
    logic            busy;

    modport master (
        input  req_valid, op_unsigned, op_rem, op_word, src1, src2, flush,
        input  div_ready, div_out_valid, div_quotient, div_remainder,
        output req_ready, div_valid, divw, div_dividend, div_divisor, div_flush,
        output res_valid, res, busy
    );

    modport slave (
        output req_valid, op_unsigned, op_rem, op_word, src1, src2, flush,
        output div_ready, div_out_valid, div_quotient, div_remainder,
        input  req_ready, div_valid, divw, div_dividend, div_divisor, div_flush,
        input  res_valid, res, busy
    );
endinterface

// File: rtl/ysyx_040729_exe_alu_div_ctrl.sv
// -----------------------------------------------------------------------------
// ysyx_040729_exe_alu_div_ctrl
//
// Purpose:
//   EXE-stage initiator for the iterative shift-subtract divider. It accepts
//   RV64M divide ops (DIV/DIVU/REM/REMU and their W forms) and works on them
//   as follows:
//   - It turns signed operands into magnitudes.
//   - It left-aligns word operands for the divider.
//   - It resolves divide-by-zero and signed overflow without the divider.
//   - It applies sign correction to the divider result.
//   - It returns one XLEN-wide result as a single-cycle pulse.
//
// Ports:
//   clock  in  system clock
//   reset  in  asynchronous, active-low reset
//   bus    ysyx_040729_exe_alu_div_ctrl_if.master
//          Carries the request, divider handshake and result signals.
//
// FSM: IDLE -> (special case) DONE -> IDLE
//      IDLE -> ISSUE -> WAIT -> DONE -> IDLE
//      A flush in ISSUE, WAIT or DONE returns to IDLE.
// -----------------------------------------------------------------------------
module ysyx_040729_exe_alu_div_ctrl #(
    parameter int XLEN = 64
) (
    input  logic                               clock,
    input  logic                               reset,
    ysyx_040729_exe_alu_div_ctrl_if.master     bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int PAD = XLEN - 32;

    // Sign- or zero-extends the low word of a register operand.
    function automatic logic [XLEN-1:0] word_ext(input logic [XLEN-1:0] v,
                                                 input logic            zext);
        return zext ? {{PAD{1'b0}}, v[31:0]} : {{PAD{v[31]}}, v[31:0]};
    endfunction

    // Selects quotient or remainder. A W form always sign-extends bit 31,
    // including the unsigned W forms.
    function automatic logic [XLEN-1:0] form_result(input logic [XLEN-1:0] q,
                                                    input logic [XLEN-1:0] r,
                                                    input logic            rem,
                                                    input logic            word);
        logic [XLEN-1:0] sel;
        sel = rem ? r : q;
        return word ? word_ext(sel, 1'b0) : sel;
    endfunction

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    state_e          state_q,    state_d;
    logic            op_rem_q,   op_rem_d;
    logic            op_word_q,  op_word_d;
    logic            neg_q_q,    neg_q_d;
    logic            neg_r_q,    neg_r_d;
    logic            divw_q,     divw_d;
    logic [XLEN-1:0] dividend_q, dividend_d;
    logic [XLEN-1:0] divisor_q,  divisor_d;
    logic [XLEN-1:0] res_q,      res_d;

    // ---------------------------------------------------------------------
    // Request decode (only meaningful in IDLE)
    // ---------------------------------------------------------------------
    logic            is_signed;
    logic [XLEN-1:0] eff1, eff2;
    logic            sign1, sign2;
    logic [XLEN-1:0] mag1, mag2;
    logic [XLEN-1:0] min_neg;
    logic            div_zero;
    logic            sgn_ovf;
    logic            accept;

    assign is_signed = ~bus.op_unsigned;
    assign eff1      = bus.op_word ? word_ext(bus.src1, bus.op_unsigned) : bus.src1;
    assign eff2      = bus.op_word ? word_ext(bus.src2, bus.op_unsigned) : bus.src2;
    assign sign1     = is_signed & eff1[XLEN-1];
    assign sign2     = is_signed & eff2[XLEN-1];
    assign mag1      = sign1 ? (~eff1 + 1'b1) : eff1;
    assign mag2      = sign2 ? (~eff2 + 1'b1) : eff2;

    // The most negative value of the effective width, already sign-extended.
    // This lets word and doubleword ops share one compare.
    assign min_neg   = bus.op_word ? {{(PAD + 1){1'b1}}, 31'b0}
                                   : {1'b1, {(XLEN - 1){1'b0}}};
    assign div_zero  = (eff2 == '0);
    assign sgn_ovf   = is_signed & (eff1 == min_neg) & (eff2 == '1);

    // flush beats a simultaneous request; the request is dropped.
    assign accept    = (state_q == IDLE) & bus.req_valid & ~bus.flush;

    // ---------------------------------------------------------------------
    // Divider result post-processing (only meaningful in WAIT)
    // ---------------------------------------------------------------------
    logic [XLEN-1:0] q_raw, r_raw;
    logic [XLEN-1:0] q_fix, r_fix;

    // A word op only trusts the low word of the divider outputs.
    assign q_raw = op_word_q ? word_ext(bus.div_quotient,  1'b1) : bus.div_quotient;
    assign r_raw = op_word_q ? word_ext(bus.div_remainder, 1'b1) : bus.div_remainder;
    assign q_fix = neg_q_q ? (~q_raw + 1'b1) : q_raw;
    assign r_fix = neg_r_q ? (~r_raw + 1'b1) : r_raw;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs, whatever the order the blocks evaluate in.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            op_rem_q   <= 1'b0;
            op_word_q  <= 1'b0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            divw_q     <= 1'b0;
            dividend_q <= '0;
            divisor_q  <= '0;
            res_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_rem_q   <= op_rem_d;
            op_word_q  <= op_word_d;
            neg_q_q    <= neg_q_d;
            neg_r_q    <= neg_r_d;
            divw_q     <= divw_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            res_q      <= res_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and datapath update
    // ---------------------------------------------------------------------
    // NOTE: every signal is given its hold value first. Each path through the
    // case therefore assigns it, and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        op_rem_d   = op_rem_q;
        op_word_d  = op_word_q;
        neg_q_d    = neg_q_q;
        neg_r_d    = neg_r_q;
        divw_d     = divw_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        res_d      = res_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_rem_d  = bus.op_rem;
                    op_word_d = bus.op_word;
                    if (div_zero) begin
                        res_d   = form_result('1, eff1, bus.op_rem, bus.op_word);
                        state_d = DONE;
                    end else if (sgn_ovf) begin
                        res_d   = form_result(eff1, '0, bus.op_rem, bus.op_word);
                        state_d = DONE;
                    end else begin
                        neg_q_d = sign1 ^ sign2;
                        neg_r_d = sign1;
                        divw_d  = bus.op_word;
                        // Word operands sit in the top half, so the divider
                        // can finish after 32 iterations.
                        dividend_d = bus.op_word ? {mag1[31:0], {PAD{1'b0}}} : mag1;
                        divisor_d  = bus.op_word ? {mag2[31:0], {PAD{1'b0}}} : mag2;
                        state_d    = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (bus.div_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (bus.div_out_valid) begin
                    res_d   = form_result(q_fix, r_fix, op_rem_q, op_word_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign bus.req_ready    = (state_q == IDLE);
    assign bus.busy         = (state_q != IDLE);
    // A flushed request must not be handed to the divider in its dying cycle.
    assign bus.div_valid    = (state_q == ISSUE) & ~bus.flush;
    assign bus.div_flush    = ((state_q == ISSUE) | (state_q == WAIT)) & bus.flush;
    // A flush in DONE drops the result pulse.
    assign bus.res_valid    = (state_q == DONE) & ~bus.flush;
    assign bus.res          = res_q;
    assign bus.divw         = divw_q;
    assign bus.div_dividend = dividend_q;
    assign bus.div_divisor  = divisor_q;

endmodule

// File: tb/tb_ysyx_040729_exe_alu_div_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for ysyx_040729_exe_alu_div_ctrl.
//
// A behavioural divider stands in for the real iterative divider. It has a
// configurable ready stall and garbage in the upper word of W-mode results.
// Expected results come from an RV64M reference function that uses plain SV
// arithmetic. A scoreboard process checks every res_valid pulse against it.
// Directed ops add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_ysyx_040729_exe_alu_div_ctrl;

    localparam int XLEN = 64;

    logic clock = 1'b0;
    logic reset = 1'b0;

    ysyx_040729_exe_alu_div_ctrl_if #(.XLEN(XLEN)) bus ();

    ysyx_040729_exe_alu_div_ctrl #(.XLEN(XLEN)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_mis = 0;

    logic [63:0] exp_q[$];

    // Divider model state and observation counters.
    int          stall_cfg  = 0;
    int          inject_cnt = 0;
    int          n_issue    = 0;
    int          n_dv       = 0;
    int          n_dflush   = 0;
    logic [63:0] last_dividend = '0;
    logic [63:0] last_divisor  = '0;
    logic        last_divw     = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // RV64M divide semantics, straight from the ISA rules.
    function automatic logic [63:0] ref_div(input bit uns, input bit rem, input bit word,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [31:0]        a32, b32, r32;
        logic signed [31:0] sa32, sb32;
        logic signed [63:0] sa, sb;
        logic [63:0]        r64;
        a32 = a[31:0];
        b32 = b[31:0];
        if (word) begin
            if (b32 == 32'h0)
                r32 = rem ? a32 : 32'hFFFF_FFFF;
            else if (!uns && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF)
                r32 = rem ? 32'h0 : a32;
            else if (uns)
                r32 = rem ? (a32 % b32) : (a32 / b32);
            else begin
                sa32 = a32;
                sb32 = b32;
                r32  = rem ? (sa32 % sb32) : (sa32 / sb32);
            end
            return {{32{r32[31]}}, r32};
        end
        if (b == 64'h0)
            r64 = rem ? a : 64'hFFFF_FFFF_FFFF_FFFF;
        else if (!uns && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
            r64 = rem ? 64'h0 : a;
        else if (uns)
            r64 = rem ? (a % b) : (a / b);
        else begin
            sa  = a;
            sb  = b;
            r64 = rem ? (sa % sb) : (sa / sb);
        end
        return r64;
    endfunction

    // ---------------------------------------------------------------------
    // Behavioural divider: samples at negedge, updates 1 time unit after posedge
    // ---------------------------------------------------------------------
    initial begin : divider_model
        bit          s_hs, s_fl, s_stall, m_busy;
        int          m_cnt, m_wait, inject_done;
        logic [63:0] mq, mr, da, db;
        m_busy = 1'b0; m_cnt = 0; m_wait = 0; inject_done = 0;
        mq = '0; mr = '0;
        bus.div_ready     = 1'b1;
        bus.div_out_valid = 1'b0;
        bus.div_quotient  = '0;
        bus.div_remainder = '0;
        forever begin
            @(negedge clock);
            s_hs    = bus.div_valid && bus.div_ready;
            s_fl    = bus.div_flush;
            s_stall = bus.div_valid && !bus.div_ready && !m_busy;
            if (bus.div_valid) n_dv++;
            if (bus.div_flush) n_dflush++;
            @(posedge clock);
            #1;
            bus.div_out_valid = 1'b0;
            if (s_fl) begin
                m_busy = 1'b0;
                m_wait = 0;
            end else if (s_hs) begin
                n_issue++;
                last_dividend = bus.div_dividend;
                last_divisor  = bus.div_divisor;
                last_divw     = bus.divw;
                da = bus.divw ? {32'h0, bus.div_dividend[63:32]} : bus.div_dividend;
                db = bus.divw ? {32'h0, bus.div_divisor[63:32]}  : bus.div_divisor;
                if (db == 64'h0) begin
                    check("divider zero divisor", 64'h1, 64'h0);
                    db = 64'h1;
                end
                mq = da / db;
                mr = da % db;
                if (bus.divw) begin
                    mq[63:32] = 32'hA5A5_A5A5;
                    mr[63:32] = 32'h5A5A_5A5A;
                end
                m_busy = 1'b1;
                m_cnt  = bus.divw ? 3 : 6;
                m_wait = 0;
            end else if (m_busy) begin
                if (m_cnt <= 1) begin
                    bus.div_out_valid = 1'b1;
                    bus.div_quotient  = mq;
                    bus.div_remainder = mr;
                    m_busy = 1'b0;
                end else begin
                    m_cnt--;
                end
            end
            if (s_stall) m_wait++;
            if (inject_cnt != inject_done) begin
                inject_done       = inject_cnt;
                bus.div_out_valid = 1'b1;
                bus.div_quotient  = 64'h55;
                bus.div_remainder = 64'h33;
            end
            bus.div_ready = !m_busy && (m_wait >= stall_cfg);
        end
    end

    // ---------------------------------------------------------------------
    // Scoreboard: every result pulse must match the next expected result
    // ---------------------------------------------------------------------
    initial begin : scoreboard
        logic [63:0] e;
        forever begin
            @(negedge clock);
            if (reset && bus.res_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected res_valid", 64'h1, 64'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("scoreboard res", bus.res, e);
                end
            end
        end
    end

    // Presents one request for one cycle. It is called 1 unit after a posedge.
    task automatic present(input bit uns, input bit rem, input bit word,
                           input logic [63:0] a, input logic [63:0] b);
        bus.op_unsigned = uns;
        bus.op_rem      = rem;
        bus.op_word     = word;
        bus.src1        = a;
        bus.src2        = b;
        bus.req_valid   = 1'b1;
        @(posedge clock);
        #1;
        bus.req_valid   = 1'b0;
    endtask

    // Runs one op to completion. It checks the literal result (when given)
    // and returns the accept-to-result latency in cycles.
    task automatic run_op(input string name, input bit uns, input bit rem, input bit word,
                          input logic [63:0] a, input logic [63:0] b,
                          input bit has_lit, input logic [63:0] lit, output int lat);
        bit          got;
        logic [63:0] r;
        got = 1'b0;
        r   = '0;
        lat = 0;
        exp_q.push_back(ref_div(uns, rem, word, a, b));
        present(uns, rem, word, a, b);
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clock);
            lat++;
            if (bus.res_valid) begin
                got = 1'b1;
                r   = bus.res;
            end
        end
        @(posedge clock);
        #1;
        check({name, " completed"}, {63'b0, got}, 64'h1);
        if (has_lit) check({name, " res"}, r, lit);
    endtask

    // Waits (bounded) for the divider to accept a request. On return the
    // DUT has just entered WAIT.
    task automatic wait_issue(input string name, input int base);
        for (int i = 0; i < 20 && n_issue == base; i++) begin
            @(posedge clock);
            #2;
        end
        check({name, " divider accepted"}, 64'(n_issue - base), 64'h1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"},    {63'b0, bus.req_ready}, 64'h1);
        check({tag, " busy"},         {63'b0, bus.busy},      64'h0);
        check({tag, " res_valid"},    {63'b0, bus.res_valid}, 64'h0);
        check({tag, " div_valid"},    {63'b0, bus.div_valid}, 64'h0);
        check({tag, " div_flush"},    {63'b0, bus.div_flush}, 64'h0);
        check({tag, " divw"},         {63'b0, bus.divw},      64'h0);
        check({tag, " res"},          bus.res,                64'h0);
        check({tag, " div_dividend"}, bus.div_dividend,       64'h0);
        check({tag, " div_divisor"},  bus.div_divisor,        64'h0);
    endtask

    // ---------------------------------------------------------------------
    // Directed sequence
    // ---------------------------------------------------------------------
    initial begin : stimulus
        int lat, base_dv, base_is, base_fl, rv_seen;

        bus.req_valid = 1'b0; bus.op_unsigned = 1'b0; bus.op_rem = 1'b0;
        bus.op_word   = 1'b0; bus.src1 = '0; bus.src2 = '0; bus.flush = 1'b0;

        // The model itself, pinned against hand-computed values.
        check("model DIV -7/2",   ref_div(0, 0, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        check("model REMW ovf",   ref_div(0, 1, 1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF), 64'h0);
        check("model DIVUW 2^31/3", ref_div(1, 0, 1, 64'h8000_0000, 64'd3), 64'h0000_0000_2AAA_AAAA);

        // Reset state
        #12;
        check_reset_outputs("in reset");
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        check_reset_outputs("after reset");

        // DIV / REM -7,2 with the divider stalling ready for two cycles
        stall_cfg = 2;
        base_dv = n_dv; base_is = n_issue;
        run_op("DIV -7/2", 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, 64'hFFFF_FFFF_FFFF_FFFD, lat);
        check("DIV -7/2 div_valid cycles", 64'(n_dv - base_dv), 64'd3);
        check("DIV -7/2 issues", 64'(n_issue - base_is), 64'd1);
        stall_cfg = 0;
        run_op("REM -7/2", 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, 64'hFFFF_FFFF_FFFF_FFFF, lat);

        // Divide by zero: one-cycle latency, divider untouched
        base_dv = n_dv;
        run_op("DIVU x/0", 1, 0, 0, 64'h1234, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFF, lat);
        check("DIVU x/0 latency", 64'(lat), 64'd1);
        run_op("REMU x/0", 1, 1, 0, 64'h1234, 64'h0, 1, 64'h1234, lat);
        check("REMU x/0 latency", 64'(lat), 64'd1);
        check("div-by-zero div_valid cycles", 64'(n_dv - base_dv), 64'd0);

        // Word signed overflow
        base_dv = n_dv;
        run_op("DIVW ovf", 0, 0, 1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'hFFFF_FFFF_8000_0000, lat);
        check("DIVW ovf latency", 64'(lat), 64'd1);
        run_op("REMW ovf", 0, 1, 1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h0, lat);
        check("overflow div_valid cycles", 64'(n_dv - base_dv), 64'd0);

        // Word alignment and sign extension of unsigned W forms
        run_op("REMUW", 1, 1, 1, 64'h1_0000_0007, 64'd3, 1, 64'h1, lat);
        check("REMUW div_dividend", last_dividend, 64'h0000_0007_0000_0000);
        check("REMUW div_divisor",  last_divisor,  64'h0000_0003_0000_0000);
        check("REMUW divw", {63'b0, last_divw}, 64'h1);
        run_op("DIVUW", 1, 0, 1, 64'hFFFF_FFFE, 64'd1, 1, 64'hFFFF_FFFF_FFFF_FFFE, lat);

        // Flush in WAIT
        base_is = n_issue; base_fl = n_dflush;
        present(0, 0, 0, 64'd100, 64'd7);
        wait_issue("flush-in-WAIT", base_is);
        bus.flush = 1'b1;
        @(negedge clock);
        check("flush WAIT div_flush", {63'b0, bus.div_flush}, 64'h1);
        @(posedge clock); #1;
        bus.flush = 1'b0;
        @(negedge clock);
        check("flush WAIT req_ready next", {63'b0, bus.req_ready}, 64'h1);
        check("flush WAIT div_flush drop", {63'b0, bus.div_flush}, 64'h0);
        repeat (10) @(posedge clock);
        #1;
        check("flush WAIT div_flush pulses", 64'(n_dflush - base_fl), 64'd1);
        run_op("DIV 100/-7", 0, 0, 0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1, 64'hFFFF_FFFF_FFFF_FFF2, lat);

        // Flush in DONE drops the result pulse
        present(1, 0, 0, 64'd5, 64'd0);
        bus.flush = 1'b1;
        @(negedge clock);
        check("flush DONE res_valid", {63'b0, bus.res_valid}, 64'h0);
        check("flush DONE div_flush", {63'b0, bus.div_flush}, 64'h0);
        @(posedge clock); #1;
        bus.flush = 1'b0;
        @(negedge clock);
        check("flush DONE idle", {63'b0, bus.req_ready}, 64'h1);

        // Flush with a request in IDLE: the request is dropped
        @(posedge clock); #1;
        bus.flush = 1'b1;
        present(0, 0, 0, 64'd9, 64'd3);
        bus.flush = 1'b0;
        @(negedge clock);
        check("flush IDLE not accepted", {63'b0, bus.busy}, 64'h0);
        @(posedge clock); #1;

        // A mix of ordinary ops, checked by the scoreboard
        run_op("DIV max/3",      0, 0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd3, 0, 64'h0, lat);
        run_op("REM -1000/33",   0, 1, 0, 64'hFFFF_FFFF_FFFF_FC18, 64'd33, 0, 64'h0, lat);
        run_op("DIVU big/16",    1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 0, 64'h0, lat);
        run_op("REMU odd/7",     1, 1, 0, 64'h8000_0000_0000_0001, 64'd7, 0, 64'h0, lat);
        run_op("DIVW -100/7",    0, 0, 1, 64'hDEAD_0000_FFFF_FF9C, 64'd7, 1, 64'hFFFF_FFFF_FFFF_FFF2, lat);
        run_op("REMW -100/7",    0, 1, 1, 64'hDEAD_0000_FFFF_FF9C, 64'd7, 1, 64'hFFFF_FFFF_FFFF_FFFE, lat);
        run_op("DIV ovf 64",     0, 0, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h0, lat);
        run_op("REM min/0",      0, 1, 0, 64'h8000_0000_0000_0000, 64'h0, 0, 64'h0, lat);
        run_op("DIVUW 2^31/3",   1, 0, 1, 64'h8000_0000, 64'd3, 0, 64'h0, lat);
        run_op("DIVW -2^31/2",   0, 0, 1, 64'h8000_0000, 64'd2, 1, 64'hFFFF_FFFF_C000_0000, lat);

        // Reset asserted during WAIT
        base_is = n_issue;
        present(0, 0, 0, 64'd100, 64'd7);
        wait_issue("reset-in-WAIT", base_is);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("mid-op reset");
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b1;
        inject_cnt++;
        rv_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (bus.res_valid) rv_seen++;
        end
        check("after reset no res_valid", 64'(rv_seen), 64'd0);
        check("after reset idle", {63'b0, bus.req_ready}, 64'h1);

        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ysyx_040729_exe_alu_div_ctrl.md
Name: ysyx_040729_exe_alu_div_ctrl

Overview:
- EXE-stage initiator for the iterative shift-subtract divider; owns the requester side of its div_valid/div_ready/out_valid handshake.
- Accepts RV64M divide ops (DIV/DIVU/REM/REMU and W forms) from the ALU.
- Converts signed operands to magnitudes, aligns word operands, and issues the request.
- Resolves divide-by-zero and signed overflow locally, applies sign correction, returns one XLEN result.

Parameters:
- XLEN, 64, datapath width; the divider is instantiated with both widths = XLEN.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  ALU presents a divide op.
- req_ready  out  1  controller idle, can accept.
- op_unsigned  in  1  1 = DIVU/REMU(W).
- op_rem  in  1  1 = remainder, 0 = quotient.
- op_word  in  1  1 = W form, 32-bit operands in src[31:0].
- src1  in  XLEN  dividend.
- src2  in  XLEN  divisor.
- flush  in  1  pipeline flush, kills in-flight op.
- div_valid  out  1  request to divider.
- div_ready  in  1  divider idle.
- divw  out  1  word-mode iteration count to divider.
- div_dividend  out  XLEN  magnitude dividend to divider.
- div_divisor  out  XLEN  magnitude divisor to divider.
- div_flush  out  1  abort to divider.
- div_out_valid  in  1  divider result strobe.
- div_quotient  in  XLEN  unsigned quotient.
- div_remainder  in  XLEN  unsigned remainder.
- res_valid  out  1  one-cycle result pulse.
- res  out  XLEN  final result.
- busy  out  1  op in flight (stall EXE).

Behaviour:
- Reset (reset=0, async): state IDLE; res_valid, div_valid, div_flush, busy = 0; res, div_dividend, div_divisor = 0; divw = 0; req_ready = 1.
- States: IDLE, ISSUE, WAIT, DONE.
- req_ready = (state==IDLE). busy = !(state==IDLE).
- IDLE:
  - Accept when req_valid, unless flush is high; flush wins and the request is dropped.
  - On accept, latch op bits and operands. Effective operands for word ops: src[31:0], sign-extended if signed, zero-extended if unsigned.
  - Divide-by-zero (effective divisor==0): result q=all-ones, r=effective dividend. Go to DONE; the divider is never requested.
  - Signed overflow (signed, dividend=most negative of the effective width, divisor=-1): result q=dividend, r=0. Go to DONE.
  - Otherwise: neg_q = signed & (sign1 ^ sign2); neg_r = signed & sign1. Compute magnitudes and go to ISSUE.
- Operand alignment:
  - Word op: div_dividend = {mag1[31:0], 32'b0}; div_divisor = {mag2[31:0], 32'b0}; divw=1.
  - Doubleword op: magnitudes passed directly; divw=0.
- ISSUE:
  - div_valid=1 while in ISSUE.
  - Go to WAIT when div_ready=1 in the same cycle; otherwise hold in ISSUE with all outputs stable.
- WAIT:
  - Wait for div_out_valid.
  - On the strobe, take q = div_quotient and r = div_remainder. Word op: use only bits [31:0] of each.
  - Negate q if neg_q; negate r if neg_r. Go to DONE.
- Result formation:
  - Select q or r by op_rem.
  - Word op: res = sign-extension of bit 31 to XLEN; this applies to unsigned W forms too.
  - res is registered when leaving WAIT, or when leaving IDLE for special cases.
- DONE: res_valid=1 for exactly one cycle, res valid that cycle, then IDLE. There is no result backpressure.
- Latency from accept to res_valid:
  - Special case: 1 cycle.
  - Normal: ISSUE + divider iterations + 1 cycle.
- flush in ISSUE/WAIT/DONE:
  - Next state IDLE; res_valid suppressed (a flush in DONE drops the pulse).
  - div_flush=1 for one cycle when flush occurs in ISSUE or WAIT.
  - A div_out_valid arriving in the flush cycle is ignored.
- div_out_valid outside WAIT: ignored.
- Reset mid-operation: immediate return to reset values; no res_valid.

Test Plan:
- DIV src1=-7, src2=2 -> res=0xFFFF_FFFF_FFFF_FFFD. REM with the same operands -> res=0xFFFF_FFFF_FFFF_FFFF. div_valid pulses once and waits for div_ready.
- DIVU src1=0x1234, src2=0 -> res=0xFFFF_FFFF_FFFF_FFFF one cycle after accept; div_valid never asserted. REMU with the same operands -> res=0x1234.
- DIVW src1=0x0000_0000_8000_0000, src2=0xFFFF_FFFF_FFFF_FFFF -> res=0xFFFF_FFFF_8000_0000 with no divider request. REMW with the same operands -> res=0.
- REMUW src1=0x1_0000_0007, src2=3 -> div_dividend=0x0000_0007_0000_0000, divw=1, res=1. DIVUW src1=0xFFFF_FFFE, src2=1 -> res=0xFFFF_FFFF_FFFF_FFFE (sign-extended).
- DIV src1=100, src2=7, flush in WAIT -> div_flush pulses once, no res_valid, req_ready=1 next cycle. A following DIV src1=100, src2=-7 -> res=-14.
- reset deasserted-then-asserted (low) during WAIT -> all outputs return to reset values immediately; a later div_out_valid produces no res_valid.
